// File: rtl/ysyx_22040750_pkg.sv
// rtl/ysyx_22040750_pkg.sv - shared constants, FSM encoding and EX->MEM payload type
package ysyx_22040750_pkg;

    localparam int XLEN    = 64;
    localparam int RD_W    = 5;
    localparam int MSIZE_W = 3;

    // Memory access size/sign codes carried in mem_size
    localparam logic [MSIZE_W-1:0] MSIZE_B  = 3'd0;
    localparam logic [MSIZE_W-1:0] MSIZE_H  = 3'd1;
    localparam logic [MSIZE_W-1:0] MSIZE_W4 = 3'd2;
    localparam logic [MSIZE_W-1:0] MSIZE_D  = 3'd3;
    localparam logic [MSIZE_W-1:0] MSIZE_BU = 3'd4;
    localparam logic [MSIZE_W-1:0] MSIZE_HU = 3'd5;
    localparam logic [MSIZE_W-1:0] MSIZE_WU = 3'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } ex_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    result;
        logic [XLEN-1:0]    store_data;
        logic [RD_W-1:0]    rd;
        logic               rd_wen;
        logic               mem_ren;
        logic               mem_wen;
        logic [MSIZE_W-1:0] mem_size;
        logic [XLEN-1:0]    pc;
    } mem_payload_t;

endpackage

// File: rtl/ysyx_22040750_pipe_slot.sv
// rtl/ysyx_22040750_pipe_slot.sv - one payload+valid pipeline register with load/clear
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   load_i, data_i    capture data_i and set valid (load wins over clear)
//   clear_i           drop valid, payload held
//   valid_o, data_o   registered valid and payload
module ysyx_22040750_pipe_slot
    import ysyx_22040750_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  mem_payload_t data_i,
    output logic         valid_o,
    output mem_payload_t data_o
);

    logic         valid_q;
    mem_payload_t data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ysyx_22040750_ex_mem_stage.sv
// rtl/ysyx_22040750_ex_mem_stage.sv - EX->MEM pipeline register with mul/div sequencing
// Optional feature macro: EX_MEM_SKID_EN (adds a skid entry, registered O_EX_MEM_ready).
// Ports:
//   I_sys_clk, I_rst            clock, synchronous active-high reset
//   I_EX_*, I_alu_*, I_rd ...   EX instruction and ALU result inputs
//   I_flush                     kill EX instruction and in-flight mul/div
//   I_MEM_ready                 MEM accepts the head entry
//   O_multicycle_start          one-cycle start pulse to the ALU
//   O_EX_MEM_ready              ALU may hand over a result this cycle
//   O_EX_ready                  EX instruction retires this cycle
//   O_MEM_valid, O_result ...   registered MEM payload
module ysyx_22040750_ex_mem_stage
    import ysyx_22040750_pkg::*;
(
    input  logic               I_sys_clk,
    input  logic               I_rst,
    input  logic               I_EX_valid,
    input  logic               I_EX_multicycle,
    input  logic [XLEN-1:0]    I_alu_result,
    input  logic               I_alu_result_valid,
    input  logic [XLEN-1:0]    I_store_data,
    input  logic [RD_W-1:0]    I_rd,
    input  logic               I_rd_wen,
    input  logic               I_mem_ren,
    input  logic               I_mem_wen,
    input  logic [MSIZE_W-1:0] I_mem_size,
    input  logic [XLEN-1:0]    I_pc,
    input  logic               I_flush,
    input  logic               I_MEM_ready,
    output logic               O_multicycle_start,
    output logic               O_EX_MEM_ready,
    output logic               O_EX_ready,
    output logic               O_MEM_valid,
    output logic [XLEN-1:0]    O_result,
    output logic [XLEN-1:0]    O_store_data,
    output logic [RD_W-1:0]    O_rd,
    output logic               O_rd_wen,
    output logic               O_mem_ren,
    output logic               O_mem_wen,
    output logic [MSIZE_W-1:0] O_mem_size,
    output logic [XLEN-1:0]    O_pc
);

    ex_state_e    state_q;
    mem_payload_t ex_payload;
    mem_payload_t head_data;
    mem_payload_t head_in;
    logic         head_valid;
    logic         head_load;
    logic         head_clear;
    logic         can_acc;
    logic         fire;

    assign ex_payload = '{result:     I_alu_result,
                          store_data: I_store_data,
                          rd:         I_rd,
                          rd_wen:     I_rd_wen,
                          mem_ren:    I_mem_ren,
                          mem_wen:    I_mem_wen,
                          mem_size:   I_mem_size,
                          pc:         I_pc};

    assign O_multicycle_start = (state_q == IDLE) & I_EX_valid & I_EX_multicycle & ~I_flush;

    assign fire = I_EX_valid & I_alu_result_valid & can_acc & ~I_flush &
                  (((state_q == IDLE) & ~I_EX_multicycle) | (state_q == BUSY));

    assign O_EX_ready     = fire;
    // While draining, the stale result must be taken off the ALU so it does not replay later.
    assign O_EX_MEM_ready = (state_q == DRAIN) | can_acc;

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:  if (O_multicycle_start) state_q <= BUSY;
                BUSY: begin
                    if (I_flush) begin
                        // A result handed over in the flush cycle is already gone; nothing left to drain.
                        state_q <= (I_alu_result_valid & can_acc) ? IDLE : DRAIN;
                    end else if (fire) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: if (I_alu_result_valid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef EX_MEM_SKID_EN
    mem_payload_t skid_data;
    logic         skid_valid;
    logic         pop;

    // Acceptance depends only on the skid register, so I_MEM_ready never reaches the ALU handshake.
    assign can_acc    = ~skid_valid;
    assign pop        = head_valid & I_MEM_ready;
    // fire implies the skid is empty, so a skid refill and a new capture never collide.
    assign head_load  = (pop & skid_valid) | (fire & (~head_valid | pop));
    assign head_in    = skid_valid ? skid_data : ex_payload;
    assign head_clear = pop;

    ysyx_22040750_pipe_slot u_skid (
        .clk_i   (I_sys_clk),
        .rst_i   (I_rst),
        .load_i  (fire & head_valid & ~pop),
        .clear_i (pop),
        .data_i  (ex_payload),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );
`else
    assign can_acc    = ~head_valid | I_MEM_ready;
    assign head_load  = fire;
    assign head_in    = ex_payload;
    assign head_clear = I_MEM_ready;
`endif

    ysyx_22040750_pipe_slot u_head (
        .clk_i   (I_sys_clk),
        .rst_i   (I_rst),
        .load_i  (head_load),
        .clear_i (head_clear),
        .data_i  (head_in),
        .valid_o (head_valid),
        .data_o  (head_data)
    );

    assign O_MEM_valid  = head_valid;
    assign O_result     = head_data.result;
    assign O_store_data = head_data.store_data;
    assign O_rd         = head_data.rd;
    assign O_rd_wen     = head_data.rd_wen;
    assign O_mem_ren    = head_data.mem_ren;
    assign O_mem_wen    = head_data.mem_wen;
    assign O_mem_size   = head_data.mem_size;
    assign O_pc         = head_data.pc;

endmodule
